// File: rtl/timer_digit_loader.sv
// Keypad front end for the MM:SS timer: shifts BCD keypresses into a four-digit buffer and
// drives the counter chain load strobe. Optional macro TIMER_SECONDS_CLAMP_EN clamps bad seconds to 59.
module timer_digit_loader #(
  parameter int LOAD_CYCLES = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enter,
  input  logic       cancel,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic       loadn,
  output logic       count_hold,
  output logic [2:0] digit_count,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_t;

  state_t     state, state_n;
  bcd_t       bcd, bcd_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] lcnt, lcnt_n;
  logic       err_n;

  // Edge detectors: bit 0 key_valid, bit 1 enter, bit 2 cancel.
  logic [2:0] prev, cur, ev;
  logic       digit_ev, enter_ev, cancel_ev;

  assign cur       = {cancel, enter, key_valid};
  assign ev        = cur & ~prev;
  assign digit_ev  = ev[0] && (key_code <= 4'd9);
  assign enter_ev  = ev[1];
  assign cancel_ev = ev[2];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      bcd   <= '0;
      cnt   <= '0;
      lcnt  <= '0;
      error <= 1'b0;
      prev  <= '0;
    end else begin
      state <= state_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      lcnt  <= lcnt_n;
      error <= err_n;
      prev  <= cur;
    end
  end

  always_comb begin
    state_n = state;
    bcd_n   = bcd;
    cnt_n   = cnt;
    lcnt_n  = lcnt;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // Buffer may still show the last loaded value; a new entry starts from 0000.
        if (cancel_ev) begin
          bcd_n = '0;
        end else if (enter_ev) begin
          bcd_n = bcd;
        end else if (digit_ev) begin
          bcd_n   = '{mt: 4'd0, mu: 4'd0, st: 4'd0, su: key_code};
          cnt_n   = 3'd1;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel_ev) begin
          bcd_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (enter_ev) begin
          if (bcd.st <= 4'd5) begin
            lcnt_n  = '0;
            state_n = LOAD;
          end else begin
`ifdef TIMER_SECONDS_CLAMP_EN
            bcd_n.st = 4'd5;
            bcd_n.su = 4'd9;
            lcnt_n   = '0;
            state_n  = LOAD;
`else
            err_n = 1'b1;
`endif
          end
        end else if (digit_ev && cnt < 3'd4) begin
          bcd_n = '{mt: bcd.mu, mu: bcd.st, st: bcd.su, su: key_code};
          cnt_n = cnt + 3'd1;
        end
      end
      LOAD: begin
        if (lcnt == 4'(LOAD_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          lcnt_n = lcnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes decode straight from state so clear releases loadn asynchronously.
  assign loadn       = (state != LOAD);
  assign count_hold  = (state == LOAD);
  assign digit_count = cnt;
  assign min_tens    = bcd.mt;
  assign min_units   = bcd.mu;
  assign sec_tens    = bcd.st;
  assign sec_units   = bcd.su;

endmodule

// File: tb/tb_timer_digit_loader.sv
// Scoreboard bench: stimulus pushes each expected output change with its cycle stamp,
// a negedge monitor pops and compares whenever a DUT's outputs change.
module tb_timer_digit_loader;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  dc;
    logic        ln;
    logic        ch;
    logic        er;
  } out_t;

  typedef struct {
    out_t v;
    int   at;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear_a, kv_a, en_a, cn_a, clear_b, kv_b, en_b, cn_b;
  logic [3:0] kc_a, kc_b;
  logic [3:0] su_a, st_a, mu_a, mt_a, su_b, st_b, mu_b, mt_b;
  logic       ln_a, ch_a, er_a, ln_b, ch_b, er_b;
  logic [2:0] dc_a, dc_b;

  out_t obs_a, obs_b, prev_a, prev_b;
  exp_t qa[$], qb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  localparam out_t RST = '{d: 16'h0000, dc: 3'd0, ln: 1'b1, ch: 1'b0, er: 1'b0};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  timer_digit_loader #(.LOAD_CYCLES(1)) dut_a (
    .clock(clock), .clear(clear_a), .key_valid(kv_a), .key_code(kc_a), .enter(en_a), .cancel(cn_a),
    .sec_units(su_a), .sec_tens(st_a), .min_units(mu_a), .min_tens(mt_a),
    .loadn(ln_a), .count_hold(ch_a), .digit_count(dc_a), .error(er_a));

  timer_digit_loader #(.LOAD_CYCLES(3)) dut_b (
    .clock(clock), .clear(clear_b), .key_valid(kv_b), .key_code(kc_b), .enter(en_b), .cancel(cn_b),
    .sec_units(su_b), .sec_tens(st_b), .min_units(mu_b), .min_tens(mt_b),
    .loadn(ln_b), .count_hold(ch_b), .digit_count(dc_b), .error(er_b));

  assign obs_a = {mt_a, mu_a, st_a, su_a, dc_a, ln_a, ch_a, er_a};
  assign obs_b = {mt_b, mu_b, st_b, su_b, dc_b, ln_b, ch_b, er_b};

  function automatic out_t mk(input logic [15:0] d, input logic [2:0] dc,
                              input logic ln, input logic ch, input logic er);
    return '{d: d, dc: dc, ln: ln, ch: ch, er: er};
  endfunction

  task automatic push(input int s, input int dt, input out_t v);
    exp_t e;
    e.v  = v;
    e.at = cyc + dt;
    if (s == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic check_chg(input int s, input out_t v);
    exp_t e;
    vectors++;
    if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d unexpected change: got %h at cycle %0d, none expected", s, v, cyc);
    end else begin
      e = (s == 0) ? qa.pop_front() : qb.pop_front();
      if (v !== e.v || cyc != e.at) begin
        miscompares++;
        $display("FAIL dut%0d change: got %h at cycle %0d, want %h at cycle %0d",
                 s, v, cyc, e.v, e.at);
      end
    end
  endtask

  task automatic check_now(input string name, input out_t got, input out_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    prev_a = RST;
    prev_b = RST;
  end

  always @(negedge clock) begin
    if (obs_a !== prev_a) begin
      check_chg(0, obs_a);
      prev_a = obs_a;
    end
    if (obs_b !== prev_b) begin
      check_chg(1, obs_b);
      prev_b = obs_b;
    end
  end

  task automatic set_in(input int s, input logic kv, input logic [3:0] kc,
                        input logic en, input logic cn);
    if (s == 0) begin
      kv_a = kv; kc_a = kc; en_a = en; cn_a = cn;
    end else begin
      kv_b = kv; kc_b = kc; en_b = en; cn_b = cn;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // One-cycle level pulse on the chosen inputs, then one idle cycle.
  task automatic pulse(input int s, input logic kv, input logic [3:0] kc,
                       input logic en, input logic cn);
    set_in(s, kv, kc, en, cn);
    step();
    set_in(s, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic key(input int s, input logic [3:0] kc, input logic [15:0] d, input logic [2:0] dc);
    push(s, 1, mk(d, dc, 1'b1, 1'b0, 1'b0));
    pulse(s, 1'b1, kc, 1'b0, 1'b0);
  endtask

  initial begin
    clear_a = 1'b1;
    clear_b = 1'b1;
    set_in(0, 1'b0, 4'd0, 1'b0, 1'b0);
    set_in(1, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) step();
    check_now("reset_a", obs_a, RST);
    check_now("reset_b", obs_b, RST);
    clear_a = 1'b0;
    clear_b = 1'b0;
    step();

    // 1,2,3,0 then enter: 12:30 loaded for one cycle
    key(0, 4'd1, 16'h0001, 3'd1);
    key(0, 4'd2, 16'h0012, 3'd2);
    key(0, 4'd3, 16'h0123, 3'd3);
    key(0, 4'd0, 16'h1230, 3'd4);
    push(0, 1, mk(16'h1230, 3'd4, 1'b0, 1'b1, 1'b0));
    push(0, 2, mk(16'h1230, 3'd0, 1'b1, 1'b0, 1'b0));
    pulse(0, 1'b0, 4'd0, 1'b1, 1'b0);

    // 5,7,5 then enter: seconds tens 7 is out of range; entry restarts from 0000
    key(0, 4'd5, 16'h0005, 3'd1);
    key(0, 4'd7, 16'h0057, 3'd2);
    key(0, 4'd5, 16'h0575, 3'd3);
`ifdef TIMER_SECONDS_CLAMP_EN
    push(0, 1, mk(16'h0559, 3'd3, 1'b0, 1'b1, 1'b0));
    push(0, 2, mk(16'h0559, 3'd0, 1'b1, 1'b0, 1'b0));
`else
    push(0, 1, mk(16'h0575, 3'd3, 1'b1, 1'b0, 1'b1));
    push(0, 2, mk(16'h0575, 3'd3, 1'b1, 1'b0, 1'b0));
`endif
    pulse(0, 1'b0, 4'd0, 1'b1, 1'b0);
    push(0, 1, mk(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0));
    pulse(0, 1'b0, 4'd0, 1'b0, 1'b1);

    // 9,9,9,9,8: fifth key ignored
    key(0, 4'd9, 16'h0009, 3'd1);
    key(0, 4'd9, 16'h0099, 3'd2);
    key(0, 4'd9, 16'h0999, 3'd3);
    key(0, 4'd9, 16'h9999, 3'd4);
    pulse(0, 1'b1, 4'd8, 1'b0, 1'b0);
    push(0, 1, mk(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0));
    pulse(0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Held key shifts once; code 12 ignored
    push(0, 1, mk(16'h0004, 3'd1, 1'b1, 1'b0, 1'b0));
    set_in(0, 1'b1, 4'd4, 1'b0, 1'b0);
    repeat (20) step();
    set_in(0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    pulse(0, 1'b1, 4'd12, 1'b0, 1'b0);

    // Cancel beats a same-cycle digit; enter in IDLE does nothing
    push(0, 1, mk(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0));
    pulse(0, 1'b1, 4'd3, 1'b0, 1'b1);
    pulse(0, 1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) step();

    // Seconds tens of exactly 5 is accepted
    key(0, 4'd5, 16'h0005, 3'd1);
    key(0, 4'd9, 16'h0059, 3'd2);
    push(0, 1, mk(16'h0059, 3'd2, 1'b0, 1'b1, 1'b0));
    push(0, 2, mk(16'h0059, 3'd0, 1'b1, 1'b0, 1'b0));
    pulse(0, 1'b0, 4'd0, 1'b1, 1'b0);

    // LOAD_CYCLES=3 instance, clear during the second low cycle
    key(1, 4'd4, 16'h0004, 3'd1);
    key(1, 4'd2, 16'h0042, 3'd2);
    push(1, 1, mk(16'h0042, 3'd2, 1'b0, 1'b1, 1'b0));
    pulse(1, 1'b0, 4'd0, 1'b1, 1'b0);
    check_now("load_b_low", obs_b, mk(16'h0042, 3'd2, 1'b0, 1'b1, 1'b0));
    push(1, 0, RST);
    clear_b = 1'b1;
    #1;
    check_now("clear_b_async", obs_b, RST);
    step();
    clear_b = 1'b0;
    repeat (5) step();

    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL pending: got %0d/%0d changes unseen, want 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
